// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the burst memory arbiter.
package mem_arb_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick. The search starts one past ptr and wraps.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int IW = $clog2(NUM_REQ);

   // Scan from farthest to nearest so the requester closest after ptr overwrites the others.
   always_comb begin
      logic [IW-1:0] j;
      j   = '0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int unsigned i = NUM_REQ; i >= 1; i--) begin
         j = IW'((32'(ptr) + i) % NUM_REQ);
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = j;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide single-port memory between NUM_REQ burst requesters.
// Bursts are granted round-robin and then issued one beat per cycle. Read bytes are
// returned to the owning requester, and dump requests are serialised against traffic.
// Optional: define MEM_ARB_PERF_CNT_EN to add the perf_busy and perf_stall counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0]              req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
   output logic [NUM_REQ-1:0]              wr_pop,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
   output logic [NUM_REQ-1:0]              rd_valid,
   output logic [DATA_WIDTH-1:0]           rd_data,
   output logic [NUM_REQ-1:0]              done,
   input  logic                            dump_req,
   output logic                            dump_ack,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_din,
   input  logic [DATA_WIDTH-1:0]           mem_dout,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0]                     perf_busy,
   output logic [31:0]                     perf_stall,
`endif
   output logic                            mem_dump
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_t             state, state_nx;
   logic [IW-1:0]          rr_ptr;
   logic [IW-1:0]          grant;
   logic                   cap_we;
   logic [ADDR_WIDTH-1:0]  cur_addr;
   logic [LEN_WIDTH-1:0]   remaining;
   logic                   rd_pend;
   logic                   accept;

   logic [NUM_REQ-1:0]     win_gnt;
   logic [IW-1:0]          win_idx;
   logic                   win_any;

   logic [ADDR_WIDTH-1:0]  addr_a  [NUM_REQ];
   logic [LEN_WIDTH-1:0]   len_a   [NUM_REQ];
   logic [DATA_WIDTH-1:0]  wdata_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_a[g]   = req_len[g*LEN_WIDTH +: LEN_WIDTH];
      assign wdata_a[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (win_gnt),
      .idx (win_idx),
      .any (win_any)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and memory-side/requester-side strobes.
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      req_ready = '0;
      dump_ack  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      wr_pop    = '0;
      done      = '0;
      case (state)
         IDLE: begin
            if (dump_req) begin
               dump_ack = 1'b1;
            end else if (win_any) begin
               req_ready = win_gnt;
               accept    = 1'b1;
               state_nx  = BURST;
            end
         end
         BURST: begin
            mem_addr      = cur_addr;
            mem_we        = cap_we;
            mem_din       = wdata_a[grant];
            wr_pop[grant] = cap_we;
            if (remaining == '0) state_nx = DRAIN;
         end
         DRAIN: begin
            done[grant] = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign mem_dump = dump_ack;

   // Burst capture on handshake, then beat address/count stepping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= IW'(NUM_REQ - 1);
         grant     <= '0;
         cap_we    <= 1'b0;
         cur_addr  <= '0;
         remaining <= '0;
         rd_pend   <= 1'b0;
      end else begin
         rd_pend <= (state == BURST) && !cap_we;
         if (accept) begin
            rr_ptr    <= win_idx;
            grant     <= win_idx;
            cap_we    <= req_we[win_idx];
            cur_addr  <= addr_a[win_idx];
            remaining <= len_a[win_idx];
         end else if (state == BURST) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
         end
      end
   end

   // Read return: the memory answers one cycle after a read beat, which is routed to the owner.
   always_comb begin
      rd_valid = '0;
      rd_data  = '0;
      if (rd_pend) begin
         rd_valid[grant] = 1'b1;
         rd_data         = mem_dout;
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   // Saturating busy and stall counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy  <= '0;
         perf_stall <= '0;
      end else begin
         if (state != IDLE && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
         if (|(req_valid & ~req_ready) && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with a behavioural byte memory.
module tb_mem_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid, req_ready, req_we, wr_pop, rd_valid, done;
   logic [47:0]   req_addr;
   logic [31:0]   req_len;
   logic [15:0]   wdata;
   logic [7:0]    rd_data, mem_din, mem_dout;
   logic          dump_req, dump_ack, mem_we, mem_dump;
   logic [23:0]   mem_addr;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0]   perf_busy, perf_stall;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int n_dump   = 0;

   logic [7:0] mem [logic [23:0]];
   logic [7:0] wq [3] = '{8'hAA, 8'hBB, 8'hCC};
   int unsigned wq_idx = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(24), .DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_len(req_len), .wr_pop(wr_pop), .wdata(wdata),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
      .dump_req(dump_req), .dump_ack(dump_ack),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
`ifdef MEM_ARB_PERF_CNT_EN
      .perf_busy(perf_busy), .perf_stall(perf_stall),
`endif
      .mem_dump(mem_dump)
   );

   function automatic logic [7:0] mrd(input logic [23:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   // Synchronous memory: registered read, read-before-write.
   always @(posedge clk) begin
      mem_dout <= mrd(mem_addr);
      if (mem_we) mem[mem_addr] = mem_din;
      if (mem_dump) n_dump++;
   end

   // Requester 1 show-ahead write queue; requester 0 always offers 5A.
   always @(posedge clk) if (wr_pop[1] && wq_idx < 2) wq_idx <= wq_idx + 1;
   assign wdata = {wq[wq_idx], 8'h5A};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [23:0] a, input logic [15:0] l);
      req_valid[i]        = v;
      req_we[i]           = we;
      req_addr[i*24 +: 24] = a;
      req_len[i*16 +: 16]  = l;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  exp_g;
      logic [23:0] ea;
      rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; dump_req = 1'b0;
      mem[24'h10] = 8'h11; mem[24'h11] = 8'h22; mem[24'h12] = 8'h33; mem[24'h13] = 8'h44;

      // Reset state
      @(negedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_rd_valid", 32'(rd_valid), 32'h0);
      chk("rst_mem_dump", 32'(mem_dump), 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // Read burst: req0 reads 0x10..0x13
      set_req(0, 1'b1, 1'b0, 24'h10, 16'd3); #1;
      chk("rd_ready", 32'(req_ready), 32'h1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk); if (k == 1) req_valid = '0; #1;
         chk("rd_addr", 32'(mem_addr), (k >= 1 && k <= 4) ? 32'h10 + 32'(k - 1) : 32'h0);
         chk("rd_valid", 32'(rd_valid), (k >= 2 && k <= 5) ? 32'h1 : 32'h0);
         chk("rd_data", 32'(rd_data), (k >= 2 && k <= 5) ? 32'h11 * 32'(k - 1) : 32'h0);
         chk("rd_done", 32'(done), (k == 5) ? 32'h1 : 32'h0);
      end

      // Contention: pointer sits at 0, so requester 1 wins first and grants alternate
      set_req(0, 1'b1, 1'b0, 24'h10, 16'd0);
      set_req(1, 1'b1, 1'b0, 24'h10, 16'd0);
      for (int b = 0; b < 4; b++) begin
         exp_g = (b % 2 == 0) ? 2'b10 : 2'b01;
         #1 chk("rr_grant", 32'(req_ready), 32'(exp_g));
         @(negedge clk); #1 chk("rr_busy_ready", 32'(req_ready), 32'h0);
         @(negedge clk); #1 chk("rr_done", 32'(done), 32'(exp_g));
         chk("rr_drain_ready", 32'(req_ready), 32'h0);
         @(negedge clk);
      end
      req_valid = '0;

      // Write AA,BB,CC from requester 1 at 0x100
      set_req(1, 1'b1, 1'b1, 24'h100, 16'd2); #1;
      chk("wr_ready", 32'(req_ready), 32'h2);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); if (k == 1) req_valid = '0; #1;
         chk("wr_pop", 32'(wr_pop), (k <= 3) ? 32'h2 : 32'h0);
         chk("wr_we", 32'(mem_we), (k <= 3) ? 32'h1 : 32'h0);
         if (k <= 3) begin
            chk("wr_addr", 32'(mem_addr), 32'h100 + 32'(k - 1));
            chk("wr_din", 32'(mem_din), 32'(wq[k - 1]));
         end
         chk("wr_done", 32'(done), (k == 4) ? 32'h2 : 32'h0);
      end
      chk("wr_mem0", 32'(mrd(24'h100)), 32'hAA);
      chk("wr_mem2", 32'(mrd(24'h102)), 32'hCC);

      // Read the written bytes back
      set_req(1, 1'b1, 1'b0, 24'h100, 16'd2); #1;
      chk("rb_ready", 32'(req_ready), 32'h2);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); if (k == 1) req_valid = '0; #1;
         chk("rb_valid", 32'(rd_valid), (k >= 2 && k <= 4) ? 32'h2 : 32'h0);
         if (k >= 2 && k <= 4) chk("rb_data", 32'(rd_data), 32'(wq[k - 2]));
         chk("rb_done", 32'(done), (k == 4) ? 32'h2 : 32'h0);
      end

      // Address wrap at the top of memory
      set_req(0, 1'b1, 1'b0, 24'hFFFFFE, 16'd2); #1;
      chk("wrap_ready", 32'(req_ready), 32'h1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); if (k == 1) req_valid = '0; #1;
         ea = 24'hFFFFFE + 24'(k - 1);
         if (k <= 3) chk("wrap_addr", 32'(mem_addr), 32'(ea));
         chk("wrap_done", 32'(done), (k == 4) ? 32'h1 : 32'h0);
      end

      // Dump wins over a simultaneous request; dump during a burst waits for IDLE
      dump_req = 1'b1;
      set_req(0, 1'b1, 1'b0, 24'h10, 16'd0); #1;
      chk("dump_strobe", 32'(mem_dump), 32'h1);
      chk("dump_ack", 32'(dump_ack), 32'h1);
      chk("dump_no_grant", 32'(req_ready), 32'h0);
      @(negedge clk); dump_req = 1'b0; #1;
      chk("dump_then_grant", 32'(req_ready), 32'h1);
      chk("dump_one_cycle", 32'(mem_dump), 32'h0);
      @(negedge clk); dump_req = 1'b1; req_valid = '0; #1;
      chk("dump_held_burst", 32'(dump_ack), 32'h0);
      @(negedge clk); #1;
      chk("dump_held_drain", 32'(dump_ack), 32'h0);
      chk("dump_drain_done", 32'(done), 32'h1);
      @(negedge clk); #1;
      chk("dump_after_drain", 32'(dump_ack), 32'h1);
      @(negedge clk); dump_req = 1'b0; #1;
      chk("dump_count", 32'(n_dump), 32'd2);

      // Reset during beat 2 of a 4-beat write
      set_req(0, 1'b1, 1'b1, 24'h200, 16'd3); #1;
      chk("rst_wr_ready", 32'(req_ready), 32'h1);
      @(negedge clk); req_valid = '0; #1;
      chk("rst_beat1_we", 32'(mem_we), 32'h1);
      @(negedge clk); #1;
      chk("rst_beat2_addr", 32'(mem_addr), 32'h201);
      #1 rst_n = 1'b0; #1;
      chk("rst_async_we", 32'(mem_we), 32'h0);
      chk("rst_async_pop", 32'(wr_pop), 32'h0);
      chk("rst_async_done", 32'(done), 32'h0);
      @(negedge clk); #1;
      chk("rst_hold_done", 32'(done), 32'h0);
      chk("rst_hold_rdv", 32'(rd_valid), 32'h0);
      rst_n = 1'b1;
      chk("rst_mem_beat1", 32'(mrd(24'h200)), 32'h5A);
      chk("rst_mem_beat2", 32'(mrd(24'h201)), 32'h00);
      set_req(0, 1'b1, 1'b0, 24'h10, 16'd0); #1;
      chk("post_rst_ready", 32'(req_ready), 32'h1);
      @(negedge clk); req_valid = '0;
      @(negedge clk); #1;
      chk("post_rst_done", 32'(done), 32'h1);
      chk("post_rst_rdv", 32'(rd_valid), 32'h1);
      chk("post_rst_data", 32'(rd_data), 32'h11);
      @(negedge clk); #1;
      chk("post_rst_idle", 32'(done), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one byte-wide single-port synchronous memory (1-cycle registered read, read-before-write, dump strobe) between NUM_REQ requesters, e.g. instruction fetch, load DMA and store DMA.
- Grants whole bursts round-robin and sequences them one byte per cycle.
- Returns read bytes to the owning requester.
- Serialises memory dump requests against traffic.
- Sits between the accelerator's memory clients and the memory instance.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 24: memory address width.
- DATA_WIDTH, 8: memory data width.
- LEN_WIDTH, 16: burst length field width; beats = req_len+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  burst request per requester
- req_ready  out  NUM_REQ  request accepted (one-hot or zero)
- req_we  in  NUM_REQ  1=write burst, 0=read burst
- req_addr  in  NUM_REQ*ADDR_WIDTH  burst base address, packed, requester i at slice i
- req_len  in  NUM_REQ*LEN_WIDTH  beats minus one
- wr_pop  out  NUM_REQ  write beat consumed this cycle
- wdata  in  NUM_REQ*DATA_WIDTH  show-ahead write byte per requester
- rd_valid  out  NUM_REQ  rd_data valid for requester i
- rd_data  out  DATA_WIDTH  read byte, shared by all requesters
- done  out  NUM_REQ  one-cycle burst completion pulse
- dump_req  in  1  request memory dump
- dump_ack  out  1  dump issued this cycle
- mem_we  out  1  to memory write enable
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_din  out  DATA_WIDTH  to memory write data
- mem_dout  in  DATA_WIDTH  from memory read data
- mem_dump  out  1  to memory dump strobe

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- States: IDLE, BURST, DRAIN. Reset: state=IDLE, rr pointer=NUM_REQ-1, all outputs 0.
- IDLE, dump priority: dump_req=1 gives mem_dump=dump_ack=1 for that cycle. No grant in that cycle. Stay in IDLE.
- IDLE, grant: otherwise the round-robin winner among req_valid gets req_ready[w]=1.
  - Search starts at pointer+1 and wraps.
  - Handshake captures grant=w, we, addr, remaining=len. Pointer<=w. Next state BURST.
  - req_ready is combinational, asserted only in IDLE.
- BURST drive, every cycle: mem_addr=cur_addr. mem_we=cap_we. mem_din=wdata[grant]. wr_pop[grant]=cap_we.
- BURST update: cur_addr<=cur_addr+1, modulo 2^ADDR_WIDTH (wraps FFFFFF->000000). Decrement remaining.
- BURST exit: leave for DRAIN after the beat with remaining=0.
- Read return: for a read beat issued in cycle t, rd_valid[grant]=1 and rd_data=mem_dout in cycle t+1.
- DRAIN: lasts one cycle. done[grant]=1. The last read byte coincides with done. Next state IDLE.
- Throughput: burst of B beats occupies B+2 cycles (IDLE accept, B BURST, DRAIN). Next accept is no earlier than the cycle after DRAIN.
- Signals outside IDLE: req_ready=0. dump_req is held off (no ack) until IDLE.
- Requester input rules: requesters keep req_* stable while req_valid and not ready. wdata is ignored outside wr_pop.
- Simultaneous req_valid and dump_req: dump wins. The request is granted next cycle if still valid.
- Reset mid-burst: immediate return to IDLE. mem_we drops asynchronously. No done or rd_valid.
- Width rule: beat count is req_len+1. req_len=0 gives one beat. Maximum is 2^LEN_WIDTH beats.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- Defined: adds outputs perf_busy (32 bit) and perf_stall (32 bit).
  - perf_busy counts cycles not in IDLE.
  - perf_stall counts cycles where any req_valid is set and that requester is not ready.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BURST, DRAIN).
- Sub-module rr_arbiter: combinational round-robin winner from request vector and pointer. Outputs one-hot grant and index. Parameter NUM_REQ.

Test Plan:
- Read burst: preload mem[0x10..0x13]=11,22,33,44; req0 read addr 0x000010 len 3 -> rd_valid[0] carries 11,22,33,44 on consecutive cycles, done[0] with 44, total 6 cycles.
- Contention: req0 and req1 both valid continuously, len 0 -> grants 0,1,0,1, never two consecutive to the same requester.
- Write then read: req1 writes AA,BB,CC at 0x000100 (wr_pop[1] three cycles), then reads len 2 -> AA,BB,CC.
- Wrap: read addr 0xFFFFFE len 2 -> mem_addr FFFFFE, FFFFFF, 000000.
- Dump contention: dump_req and req0 asserted together in IDLE -> mem_dump one cycle, req0 granted next cycle. dump_req during BURST -> ack only after DRAIN.
- Reset mid-burst: rst_n low during beat 2 of a 4-beat write -> mem_we=0 immediately, no done. After release, new request is granted and completes normally.
